pipe_ctrl: RTL and testbench

//  Consumer end of the hazard unit's stall request: turns load-use stall, EX branch redirect and

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_perf_cnt.sv | 23 ++
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline control block: FSM state encoding,
// the per-stage enable bundle and its fixed output patterns.
package pipe_ctrl_pkg;

    localparam int MEM_TIMEOUT_DEF = 255;
    localparam int CNT_W_DEF       = 8;
    localparam int PERF_W_DEF      = 32;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_flush;
        logic ex_mem_we;
        logic mem_wb_we;
    } pipe_en_t;

    // A flushed register is also written, so every flush bit comes with its we bit,
    // except while reset holds the whole pipeline still.
    localparam pipe_en_t EN_RESET      = 7'b0010100;
    localparam pipe_en_t EN_FREEZE     = 7'b0000000;
    localparam pipe_en_t EN_REDIRECT   = 7'b1111111;
    localparam pipe_en_t EN_STALL      = 7'b0001111;
    localparam pipe_en_t EN_FETCH_WAIT = 7'b0111011;
    localparam pipe_en_t EN_RUN        = 7'b1101011;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running event counter: increments when en is high, wraps, async active-low clear.
module pipe_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline register enable/flush decode for the 5-stage core, with wrong-path fetch
// discard and dmem hang timeout. Define PIPE_PERF_EN to add stall/redirect counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
`ifdef PIPE_PERF_EN
    ,
    parameter int PERF_W      = PERF_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hdu_stall,
    input  logic              ex_redirect,
    input  logic              imem_busy,
    input  logic              dmem_busy,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              id_ex_we,
    output logic              id_ex_flush,
    output logic              ex_mem_we,
    output logic              mem_wb_we,
    output logic              dmem_timeout
`ifdef PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush
`endif
);

    state_e             state_q, state_d;
    logic               discard_q, discard_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    pipe_en_t           en;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        en        = EN_RUN;
        discard_d = discard_q;
        if (!rst_n) begin
            en = EN_RESET;
        end else if (dmem_busy) begin
            en = EN_FREEZE;
        end else if (ex_redirect) begin
            en        = EN_REDIRECT;
            discard_d = discard_q | imem_busy;
        end else if (hdu_stall) begin
            en = EN_STALL;
        end else if (discard_q || imem_busy) begin
            en = EN_FETCH_WAIT;
            // The late wrong-path word lands this cycle; PC already holds the target.
            if (discard_q && !imem_busy) begin
                discard_d = 1'b0;
            end
        end
    end

    // The entry cycle counts, so wait_cnt equals (consecutive busy cycles - 1).
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q | (dmem_busy && (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)));
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (dmem_busy) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!dmem_busy) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (!(&wait_cnt_q)) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all of it is reset, there is no memory array here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            discard_q  <= 1'b0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign pc_we        = en.pc_we;
    assign if_id_we     = en.if_id_we;
    assign if_id_flush  = en.if_id_flush;
    assign id_ex_we     = en.id_ex_we;
    assign id_ex_flush  = en.id_ex_flush;
    assign ex_mem_we    = en.ex_mem_we;
    assign mem_wb_we    = en.mem_wb_we;
    assign dmem_timeout = timeout_q;

`ifdef PIPE_PERF_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = !en.pc_we;
    assign flush_evt = ex_redirect && !dmem_busy;

    pipe_perf_cnt #(.W(PERF_W)) u_perf_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_evt),
        .count (perf_stall)
    );

    pipe_perf_cnt #(.W(PERF_W)) u_perf_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush_evt),
        .count (perf_flush)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// against a cycle-level reference model.
module tb_pipe_ctrl;

    localparam int MEM_TIMEOUT = 4;

    localparam logic [6:0] E_RESET  = 7'b0010100;
    localparam logic [6:0] E_FREEZE = 7'b0000000;
    localparam logic [6:0] E_REDIR  = 7'b1111111;
    localparam logic [6:0] E_STALL  = 7'b0001111;
    localparam logic [6:0] E_FWAIT  = 7'b0111011;
    localparam logic [6:0] E_RUN    = 7'b1101011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hdu_stall = 1'b0, ex_redirect = 1'b0, imem_busy = 1'b0, dmem_busy = 1'b0;
    logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we;
    logic dmem_timeout;
    logic [6:0] en_obs;
`ifdef PIPE_PERF_EN
    logic [31:0] perf_stall, perf_flush;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hdu_stall    (hdu_stall),
        .ex_redirect  (ex_redirect),
        .imem_busy    (imem_busy),
        .dmem_busy    (dmem_busy),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .if_id_flush  (if_id_flush),
        .id_ex_we     (id_ex_we),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
        .dmem_timeout (dmem_timeout)
`ifdef PIPE_PERF_EN
        ,
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush)
`endif
    );

    assign en_obs = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we};

    // Stimulus word: {hdu_stall, ex_redirect, imem_busy, dmem_busy}. Returns at the
    // following negedge so combinational outputs can be sampled mid-cycle.
    task automatic drive(input logic [3:0] s);
        @(posedge clk);
        #1;
        {hdu_stall, ex_redirect, imem_busy, dmem_busy} = s;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        {hdu_stall, ex_redirect, imem_busy, dmem_busy} = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference: priority list applied to the current inputs and pending discard.
    function automatic logic [6:0] model_en(input logic rstn, hs, rd, ib, db, disc);
        if (!rstn)            return E_RESET;
        else if (db)          return E_FREEZE;
        else if (rd)          return E_REDIR;
        else if (hs)          return E_STALL;
        else if (disc || ib)  return E_FWAIT;
        else                  return E_RUN;
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (en_obs !== E_RESET) begin
            errors++;
            $display("FAIL reset_enables: got %b expected %b", en_obs, E_RESET);
        end
        @(negedge clk);
        checks++;
        if (dmem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout: got %b expected 0", dmem_timeout);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_stall();
        logic [3:0] stim [2] = '{4'b1000, 4'b0000};
        logic [6:0] exp  [2] = '{E_STALL, E_RUN};
        for (int i = 0; i < 2; i++) begin
            drive(stim[i]);
            checks++;
            if (en_obs !== exp[i]) begin
                errors++;
                $display("FAIL stall[%0d]: got %b expected %b", i, en_obs, exp[i]);
            end
        end
    endtask

    task automatic test_redirect_over_stall();
        logic [3:0] stim [2] = '{4'b1100, 4'b0000};
        logic [6:0] exp  [2] = '{E_REDIR, E_RUN};
        for (int i = 0; i < 2; i++) begin
            drive(stim[i]);
            checks++;
            if (en_obs !== exp[i]) begin
                errors++;
                $display("FAIL redirect_stall[%0d]: got %b expected %b", i, en_obs, exp[i]);
            end
        end
    endtask

    task automatic test_discard();
        logic [3:0] stim [5] = '{4'b0110, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic [6:0] exp  [5] = '{E_REDIR, E_FWAIT, E_FWAIT, E_FWAIT, E_RUN};
        for (int i = 0; i < 5; i++) begin
            drive(stim[i]);
            checks++;
            if (en_obs !== exp[i]) begin
                errors++;
                $display("FAIL discard[%0d]: got %b expected %b", i, en_obs, exp[i]);
            end
        end
    endtask

    // Discard set, then a 5-cycle freeze holding a redirect; the redirect lands on
    // cycle 6 and the surviving discard drops one more fetch.
    task automatic test_freeze();
        logic [3:0] stim [9] = '{4'b0110, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
                                 4'b0100, 4'b0000, 4'b0000};
        logic [6:0] exp  [9] = '{E_REDIR, E_FREEZE, E_FREEZE, E_FREEZE, E_FREEZE, E_FREEZE,
                                 E_REDIR, E_FWAIT, E_RUN};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(stim[i]);
            checks++;
            if (en_obs !== exp[i]) begin
                errors++;
                $display("FAIL freeze[%0d]: got %b expected %b", i, en_obs, exp[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [6:0] exp_en;
        logic       exp_to;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            drive((k <= 10) ? 4'b0001 : 4'b0000);
            exp_en = (k <= 10) ? E_FREEZE : E_RUN;
            exp_to = (k >= MEM_TIMEOUT + 1);
            checks += 2;
            if (en_obs !== exp_en) begin
                errors++;
                $display("FAIL timeout_en[%0d]: got %b expected %b", k, en_obs, exp_en);
            end
            if (dmem_timeout !== exp_to) begin
                errors++;
                $display("FAIL timeout_flag[%0d]: got %b expected %b", k, dmem_timeout, exp_to);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(4'b0110);
        for (int k = 0; k < 5; k++) drive(4'b0011);
        checks++;
        if (dmem_timeout !== 1'b1) begin
            errors++;
            $display("FAIL midwait_timeout_set: got %b expected 1", dmem_timeout);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checks += 2;
        if (en_obs !== E_RESET) begin
            errors++;
            $display("FAIL midwait_reset_en: got %b expected %b", en_obs, E_RESET);
        end
        if (dmem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset_timeout: got %b expected 0", dmem_timeout);
        end
`ifdef PIPE_PERF_EN
        checks++;
        if (perf_stall !== 32'd0 || perf_flush !== 32'd0) begin
            errors++;
            $display("FAIL midwait_reset_perf: got %0d/%0d expected 0/0", perf_stall, perf_flush);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        {hdu_stall, ex_redirect, imem_busy, dmem_busy} = 4'b0000;
        @(negedge clk);
        checks += 2;
        if (en_obs !== E_RUN) begin
            errors++;
            $display("FAIL midwait_after_en: got %b expected %b", en_obs, E_RUN);
        end
        if (dmem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL midwait_after_timeout: got %b expected 0", dmem_timeout);
        end
    endtask

    task automatic test_random();
        logic       m_disc = 1'b0;
        logic       m_to = 1'b0;
        int         m_busy_run = 0;
        logic [31:0] m_pstall = '0, m_pflush = '0;
        logic       r, hs, rd, ib, db;
        logic [6:0] exp_en;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 63) != 0);
            hs = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 4) == 0);
            ib = ($urandom_range(0, 4) < 2);
            db = ($urandom_range(0, 4) == 0);
            @(posedge clk);
            #1;
            rst_n = r;
            {hdu_stall, ex_redirect, imem_busy, dmem_busy} = {hs, rd, ib, db};
            @(negedge clk);
            exp_en = model_en(r, hs, rd, ib, db, m_disc);
            if (!r) begin
                m_disc = 1'b0;
                m_to = 1'b0;
                m_busy_run = 0;
                m_pstall = '0;
                m_pflush = '0;
            end
            checks += 2;
            if (en_obs !== exp_en) begin
                errors++;
                $display("FAIL random_en[%0d]: got %b expected %b (in=%b%b%b%b rst_n=%b)",
                         n, en_obs, exp_en, hs, rd, ib, db, r);
            end
            if (dmem_timeout !== m_to) begin
                errors++;
                $display("FAIL random_timeout[%0d]: got %b expected %b", n, dmem_timeout, m_to);
            end
`ifdef PIPE_PERF_EN
            checks++;
            if (perf_stall !== m_pstall || perf_flush !== m_pflush) begin
                errors++;
                $display("FAIL random_perf[%0d]: got %0d/%0d expected %0d/%0d",
                         n, perf_stall, perf_flush, m_pstall, m_pflush);
            end
`endif
            if (r) begin
                if (!exp_en[6]) m_pstall++;
                if (rd && !db)  m_pflush++;
                if (db) begin
                    m_busy_run++;
                    if (m_busy_run >= MEM_TIMEOUT) m_to = 1'b1;
                end else begin
                    m_busy_run = 0;
                    if (rd)                    m_disc = m_disc | ib;
                    else if (!hs && m_disc && !ib) m_disc = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_over_stall();
        test_discard();
        test_freeze();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
